cal_trg_gen: RTL

CAL_TRG_GEN -- requirements
Module: cal_trg_gen

---
 rtl/cal_trg_if.sv | 27 ++
 rtl/cal_trg_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cal_trg_if.sv
// Signal bundle between a calibration host and the calibration trigger generator.
// The host drives the configuration and START; the generator returns strobes and status.
interface cal_trg_if;
  logic       CMODE;
  logic       CALTRGSEL;
  logic       START;
  logic [5:0] STRIP_MASK;
  logic [5:0] L1LATNCY;
  logic [1:0] XL1ADLY;
  logic [7:0] NPULSE;
  logic [7:0] GAPDLY;
  logic [5:0] CSTRIP;
  logic       CGTRG;
  logic       BUSY;
  logic       DONE;
  logic [7:0] PCNT;

  modport master (
    output CMODE, CALTRGSEL, START, STRIP_MASK, L1LATNCY, XL1ADLY, NPULSE, GAPDLY,
    input  CSTRIP, CGTRG, BUSY, DONE, PCNT
  );

  modport slave (
    input  CMODE, CALTRGSEL, START, STRIP_MASK, L1LATNCY, XL1ADLY, NPULSE, GAPDLY,
    output CSTRIP, CGTRG, BUSY, DONE, PCNT
  );
endinterface

// File: rtl/cal_trg_gen.sv
// Calibration trigger generator: issues bursts of LCT/L1A strobe pairs with a
// programmable LCT-to-L1A latency and a minimum-bounded gap between pairs.
//
// state | meaning
// IDLE  | waiting for START with the generator enabled
// LCT   | CSTRIP carries the captured strip mask for one cycle
// WAIT  | LCT-to-L1A latency countdown (D-1 cycles)
// L1A   | CGTRG high for one cycle, pair counted
// GAP   | spacing countdown before the next LCT (G cycles)
// FIN   | DONE pulse, then back to IDLE
module cal_trg_gen #(
  parameter int MIN_GAP = 4
) (
  input  logic      CLK,
  input  logic      RST,
  cal_trg_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LCT  = 3'd1,
    S_WAIT = 3'd2,
    S_L1A  = 3'd3,
    S_GAP  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [7:0] MIN_GAP_W = 8'(MIN_GAP);

  state_t     state_q, state_d;
  logic [5:0] mask_q, mask_d;
  logic [7:0] npulse_q, npulse_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [5:0] cstrip_q, cstrip_d;
  logic       cgtrg_q, cgtrg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       en;
  logic       accept;
  logic [7:0] dly_raw;
  logic [7:0] dly_eff;
  logic [7:0] gap_max;
  logic [7:0] gap_eff;

  assign en      = bus.CMODE & bus.CALTRGSEL;
  assign accept  = (state_q == S_IDLE) && en && bus.START;

  // Latency is at most 63 + 48 = 111, so 8 bits never overflow.
  assign dly_raw = {2'b00, bus.L1LATNCY} + {2'b00, bus.XL1ADLY, 4'b0000};
  assign dly_eff = (dly_raw < 8'd2) ? 8'd2 : dly_raw;
  assign gap_max = (bus.GAPDLY > MIN_GAP_W) ? bus.GAPDLY : MIN_GAP_W;
  assign gap_eff = (gap_max == 8'd0) ? 8'd1 : gap_max;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      mask_q   <= 6'h00;
      npulse_q <= 8'h00;
      dly_q    <= 8'h00;
      gap_q    <= 8'h00;
      cnt_q    <= 8'h00;
      pcnt_q   <= 8'h00;
      cstrip_q <= 6'h00;
      cgtrg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      npulse_q <= npulse_d;
      dly_q    <= dly_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      cstrip_q <= cstrip_d;
      cgtrg_q  <= cgtrg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (bus.NPULSE == 8'd0) ? S_FIN : S_LCT;
        end
      end
      S_LCT:  state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_L1A;
        end
      end
      S_L1A:  state_d = (pcnt_q == npulse_q) ? S_FIN : S_GAP;
      S_GAP: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_LCT;
        end
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Losing the enable aborts the burst from any active state.
    if ((state_q != S_IDLE) && !en) begin
      state_d = S_IDLE;
    end
  end

  // Outputs are registered: their next values are derived from the next state.
  always_comb begin
    mask_d   = mask_q;
    npulse_d = npulse_q;
    dly_d    = dly_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    cstrip_d = 6'h00;
    cgtrg_d  = 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);

    if (accept) begin
      mask_d   = bus.STRIP_MASK;
      npulse_d = bus.NPULSE;
      dly_d    = dly_eff;
      gap_d    = gap_eff;
      pcnt_d   = 8'h00;
    end

    if (state_d == S_LCT) begin
      cstrip_d = (state_q == S_IDLE) ? bus.STRIP_MASK : mask_q;
    end

    if (state_d == S_L1A) begin
      cgtrg_d = 1'b1;
      pcnt_d  = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
    end

    if ((state_q == S_LCT) && (state_d == S_WAIT)) begin
      cnt_d = dly_q - 8'd1;
    end else if ((state_q == S_L1A) && (state_d == S_GAP)) begin
      cnt_d = gap_q;
    end else if (((state_q == S_WAIT) || (state_q == S_GAP)) && (cnt_q > 8'd1)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  assign bus.CSTRIP = cstrip_q;
  assign bus.CGTRG  = cgtrg_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.PCNT   = pcnt_q;

endmodule
